// File: rtl/grf_writeback.sv
// grf_writeback: MIPS W stage. Selects and extends write-back data, commits
// it to the 32x32 register file, serves two D-stage read ports with
// write-through bypass, and counts retired (non-bubble) instructions.
module grf_writeback #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_W,
    input  logic [31:0]         DMout_W,
    input  logic [31:0]         ALUout_W,
    input  logic [4:0]          A3_W,
    input  logic [31:0]         PC_plus8_W,
    input  logic [4:0]          A1_D,
    input  logic [4:0]          A2_D,
    output logic [31:0]         RD1_D,
    output logic [31:0]         RD2_D,
    output logic [31:0]         WD_W,
    output logic [4:0]          A3_fwd_W,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        we;
    logic        unused_instr_bits;

    // Entry 0 is held at zero by reset and never written; reads of address 0
    // are forced to zero on the read path regardless.
    logic [31:0] regs [0:31];

    assign opcode            = instr_W[31:26];
    assign funct             = instr_W[5:0];
    assign off               = ALUout_W[1:0];
    assign we                = (A3_W != 5'd0);
    assign A3_fwd_W          = A3_W;
    assign unused_instr_bits = ^instr_W[25:6];

    // Byte and halfword lanes of the loaded word picked by the address offset.
    always_comb begin
        load_byte = DMout_W[7:0];
        case (off)
            2'd0:    load_byte = DMout_W[7:0];
            2'd1:    load_byte = DMout_W[15:8];
            2'd2:    load_byte = DMout_W[23:16];
            default: load_byte = DMout_W[31:24];
        endcase
        load_half = off[1] ? DMout_W[31:16] : DMout_W[15:0];
    end

    // Write-back data select and extension.
    always_comb begin
        WD_W = ALUout_W;
        case (opcode)
            OP_LW:      WD_W = DMout_W;
            OP_LB:      WD_W = {{24{load_byte[7]}}, load_byte};
            OP_LBU:     WD_W = {24'd0, load_byte};
            OP_LH:      WD_W = {{16{load_half[15]}}, load_half};
            OP_LHU:     WD_W = {16'd0, load_half};
            OP_JAL:     WD_W = PC_plus8_W;
            OP_SPECIAL: WD_W = (funct == FN_JALR) ? PC_plus8_W : ALUout_W;
            default:    WD_W = ALUout_W;
        endcase
    end

    // Read ports: zero register, then same-cycle write-through, then storage.
    always_comb begin
        if (A1_D == 5'd0)
            RD1_D = 32'd0;
        else if (we && (A1_D == A3_W))
            RD1_D = WD_W;
        else
            RD1_D = regs[A1_D];

        if (A2_D == 5'd0)
            RD2_D = 32'd0;
        else if (we && (A2_D == A3_W))
            RD2_D = WD_W;
        else
            RD2_D = regs[A2_D];
    end

    // Register commit and retire counter; reset clears both at assertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
            retired <= '0;
        end else begin
            if (we)
                regs[A3_W] <= WD_W;
            if (instr_W != 32'd0)
                retired <= retired + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_grf_writeback.sv
// Bench for grf_writeback: directed vectors push hand-computed expectations
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_grf_writeback;

    localparam logic [31:0] ADDU = 32'h0000_0021;
    localparam logic [31:0] JAL  = 32'h0C00_0000;
    localparam logic [31:0] JALR = 32'h0000_0009;
    localparam logic [31:0] LB   = 32'h8000_0000;
    localparam logic [31:0] LH   = 32'h8400_0000;
    localparam logic [31:0] LW   = 32'h8C00_0000;
    localparam logic [31:0] LBU  = 32'h9000_0000;
    localparam logic [31:0] LHU  = 32'h9400_0000;

    localparam int K_RD1 = 0;
    localparam int K_RD2 = 1;
    localparam int K_WD  = 2;
    localparam int K_A3F = 3;
    localparam int K_RET = 4;
    localparam int K_RT3 = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_W, DMout_W, ALUout_W, PC_plus8_W;
    logic [4:0]  A3_W, A1_D, A2_D;
    logic [31:0] RD1_D, RD2_D, WD_W;
    logic [4:0]  A3_fwd_W;
    logic [31:0] retired;
    logic [31:0] RD1_3, RD2_3, WD_3;
    logic [4:0]  A3f_3;
    logic [2:0]  retired3;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    grf_writeback #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .instr_W(instr_W), .DMout_W(DMout_W),
        .ALUout_W(ALUout_W), .A3_W(A3_W), .PC_plus8_W(PC_plus8_W),
        .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .WD_W(WD_W), .A3_fwd_W(A3_fwd_W), .retired(retired)
    );

    grf_writeback #(.RETIRE_W(3)) dut3 (
        .clk(clk), .reset(reset), .instr_W(instr_W), .DMout_W(DMout_W),
        .ALUout_W(ALUout_W), .A3_W(A3_W), .PC_plus8_W(PC_plus8_W),
        .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_3), .RD2_D(RD2_3),
        .WD_W(WD_3), .A3_fwd_W(A3f_3), .retired(retired3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        sb_entry_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge (the falling edge, where the
    // monitor samples, lies in between).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [31:0] ins, input logic [31:0] alu, input logic [4:0] a3);
        instr_W  = ins;
        ALUout_W = alu;
        A3_W     = a3;
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_entry_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RD1:   act = RD1_D;
                K_RD2:   act = RD2_D;
                K_WD:    act = WD_W;
                K_A3F:   act = {27'd0, A3_fwd_W};
                K_RET:   act = retired;
                default: act = {29'd0, retired3};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        reset = 1'b0;
        instr_W = '0; DMout_W = '0; ALUout_W = '0; PC_plus8_W = '0;
        A3_W = '0; A1_D = '0; A2_D = '0;
        cyc();
        A1_D = 5'd5; A2_D = 5'd31;
        expect_val("reset_rd1", K_RD1, 32'd0);
        expect_val("reset_rd2", K_RD2, 32'd0);
        expect_val("reset_retired", K_RET, 32'd0);
        cyc();
        reset = 1'b1;

        // Write reg 5, then pull reset low between edges.
        set_w(ADDU, 32'hDEAD_BEEF, 5'd5);
        expect_val("wr5_bypass", K_RD1, 32'hDEAD_BEEF);
        expect_val("wr5_a3fwd", K_A3F, 32'd5);
        cyc();
        set_w(32'd0, 32'd0, 5'd0);
        expect_val("wr5_stored", K_RD1, 32'hDEAD_BEEF);
        expect_val("retired_one", K_RET, 32'd1);
        cyc();
        reset = 1'b0;
        set_w(ADDU, 32'h0000_1234, 5'd0);
        A1_D = 5'd5; A2_D = 5'd0;
        expect_val("async_clear_rd1", K_RD1, 32'd0);
        expect_val("async_clear_retired", K_RET, 32'd0);
        expect_val("reg0_read", K_RD2, 32'd0);
        expect_val("wd_no_write", K_WD, 32'h0000_1234);
        cyc();
        reset = 1'b1;
        cyc();
        set_w(32'd0, 32'd0, 5'd0);
        expect_val("a3zero_no_change_rd1", K_RD1, 32'd0);
        expect_val("a3zero_reg0", K_RD2, 32'd0);
        cyc();

        // ALU write with dual-port bypass.
        set_w(ADDU, 32'h0000_0007, 5'd8);
        A1_D = 5'd8; A2_D = 5'd8;
        expect_val("alu_bypass_rd1", K_RD1, 32'd7);
        expect_val("alu_bypass_rd2", K_RD2, 32'd7);
        cyc();
        set_w(32'd0, 32'd0, 5'd0);
        expect_val("alu_stored_rd1", K_RD1, 32'd7);
        expect_val("alu_stored_rd2", K_RD2, 32'd7);
        cyc();

        // Load extension.
        DMout_W = 32'h80FF_7F01;
        set_w(LB,  32'h0000_1003, 5'd0); expect_val("lb_off3",  K_WD, 32'hFFFF_FF80); cyc();
        set_w(LBU, 32'h0000_1003, 5'd0); expect_val("lbu_off3", K_WD, 32'h0000_0080); cyc();
        set_w(LB,  32'h0000_1001, 5'd0); expect_val("lb_off1",  K_WD, 32'h0000_007F); cyc();
        set_w(LH,  32'h0000_1002, 5'd0); expect_val("lh_off2",  K_WD, 32'hFFFF_80FF); cyc();
        set_w(LHU, 32'h0000_1000, 5'd0); expect_val("lhu_off0", K_WD, 32'h0000_7F01); cyc();
        set_w(LW,  32'h0000_1000, 5'd0); expect_val("lw",       K_WD, 32'h80FF_7F01); cyc();

        // Link writes.
        PC_plus8_W = 32'h0000_3008;
        set_w(JAL, 32'h0000_AAAA, 5'd31);
        expect_val("jal_wd", K_WD, 32'h0000_3008);
        cyc();
        set_w(32'd0, 32'd0, 5'd0);
        A1_D = 5'd31;
        expect_val("jal_r31", K_RD1, 32'h0000_3008);
        cyc();
        set_w(JALR, 32'h0000_AAAA, 5'd4);
        expect_val("jalr_wd", K_WD, 32'h0000_3008);
        cyc();
        set_w(32'd0, 32'd0, 5'd0);
        A2_D = 5'd4;
        expect_val("jalr_r4", K_RD2, 32'h0000_3008);
        cyc();

        // Back-to-back writes to reg 3.
        A1_D = 5'd3;
        set_w(ADDU, 32'd1, 5'd3); expect_val("b2b_first",  K_RD1, 32'd1); cyc();
        set_w(ADDU, 32'd2, 5'd3); expect_val("b2b_second", K_RD1, 32'd2); cyc();
        set_w(32'd0, 32'd0, 5'd0); expect_val("b2b_stored", K_RD1, 32'd2); cyc();

        // Retire counter: alternating bubbles after a fresh reset.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        A1_D = 5'd8; A2_D = 5'd31;
        expect_val("reset_clears_r8",  K_RD1, 32'd0);
        expect_val("reset_clears_r31", K_RD2, 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_w((i % 2 == 1) ? ADDU : 32'd0, 32'd0, 5'd0);
            cyc();
        end
        set_w(32'd0, 32'd0, 5'd0);
        expect_val("retired_alt",  K_RET, 32'd5);
        expect_val("retired3_alt", K_RT3, 32'd5);
        cyc();

        // Retire counter wrap on the 3-bit instance.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_w(ADDU, 32'd0, 5'd0);
            cyc();
        end
        set_w(32'd0, 32'd0, 5'd0);
        expect_val("retired_nine",  K_RET, 32'd9);
        expect_val("retired3_wrap", K_RT3, 32'd1);
        cyc();
        cyc();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
